psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
- Two-client round-robin arbiter and sequencer in front of the 8-bit PSRAM controller's single-command port (stb/we/addr/din in; busy/done/dout out).
- Latches each client's command and issues one PSRAM access at a time.
- Returns read data and a completion or error pulse to the owning client.
- Watchdog aborts if the controller fails to accept or complete a command.

Parameters:
TIMEOUT_CYC, 64, max cycles in WAIT_ACC or WAIT_DONE before abort (≥4)
CNT_W, 7, width of watchdog counter; must hold TIMEOUT_CYC

Ports:
- arst_n  in  1  asynchronous reset, active-low
- i_clk  in  1  clock
- c0_req  in  1  client 0 request; level; sampled only when c0_ack can fire
- c0_we  in  1  client 0: 1=write, 0=read
- c0_addr  in  24  client 0 word address
- c0_din  in  16  client 0 write data
- c0_ack  out  1  one-cycle pulse: command latched
- c0_done  out  1  one-cycle pulse: access finished
- c0_err  out  1  one-cycle pulse with c0_done: access aborted by watchdog
- c0_dout  out  16  read data; valid when c0_done=1 and c0_err=0; held until next c0 read completes
- c1_req, c1_we, c1_addr, c1_din, c1_ack, c1_done, c1_err, c1_dout: identical set for client 1
- m_stb  out  1  command strobe to controller
- m_we  out  1  to controller
- m_addr  out  24  to controller
- m_din  out  16  to controller
- m_busy  in  1  controller busy
- m_done  in  1  controller idle/done level
- m_dout  in  16  controller read data

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE; all outputs 0; c*_dout=0; last_grant=1, so client 0 wins first; watchdog=0.
- m_ready = m_done & ~m_busy. Nothing is issued while the controller is in power-up init (busy=1).
- Internal states: IDLE, ISSUE, WAIT_ACC, WAIT_DONE.
- IDLE:
  - If m_ready and any req: pick the winner.
  - Single requester wins.
  - If both requesters: the one not equal to last_grant wins.
  - Winner gets c*_ack=1 next cycle. Latch we/addr/din into m_* regs and owner into gnt. Go to ISSUE.
- ISSUE: m_stb=1 for exactly this one cycle with latched m_*. Watchdog cleared. Go to WAIT_ACC.
- WAIT_ACC:
  - If m_busy=1 or m_done=0: command accepted; go to WAIT_DONE.
  - Otherwise increment watchdog.
- WAIT_DONE:
  - On m_ready: pulse c{gnt}_done.
  - If the owner's latched we=0, load c{gnt}_dout <= m_dout on the same edge.
  - Set last_grant <= gnt. Go to IDLE.
  - Otherwise increment watchdog.
- Watchdog: when it reaches TIMEOUT_CYC-1 in WAIT_ACC or WAIT_DONE:
  - Pulse c{gnt}_done and c{gnt}_err together.
  - dout unchanged, last_grant <= gnt, go to IDLE.
- m_we/m_addr/m_din hold their latched values from ISSUE until the next ISSUE. They are not valid outside m_stb.
- Requests are not queued:
  - A client holds req until its ack.
  - req dropped before ack is a legal cancel.
  - A client's req during its own in-flight access is ignored until IDLE.
- Back-to-back:
  - Minimum one IDLE cycle between done and the next ack.
  - Both clients continuously requesting alternate 0,1,0,1.
- Ack and done never occur in the same cycle for the same client.
- At most one client has an outstanding access.
- Reset asserted mid-access: immediate return to reset values. No done pulse is generated. The controller is reset by the same arst_n.

Test Plan:
- Release reset with model holding m_busy=1 for 100 cycles; c0_req=1 throughout -> no c0_ack and no m_stb until m_ready; then c0_ack, next cycle single-cycle m_stb.
- c0 write addr 24'h123456 din 16'hBEEF -> m_stb with m_we=1, m_addr=24'h123456, m_din=16'hBEEF; c0_done pulse when model returns ready; c0_err=0; c1 outputs quiet.
- c1 read addr 24'h000010, model returns m_dout=16'hA5C3 -> c1_done pulse, c1_dout=16'hA5C3 held afterward; c0_dout unchanged.
- c0_req and c1_req both held high for 6 accesses -> grant order 0,1,0,1,0,1; each ack exactly once per access; m_stb never overlaps an outstanding access.
- Model never raises busy after m_stb (TIMEOUT_CYC=64) -> c0_done and c0_err pulse together 64 cycles later; next request is serviced normally.
- arst_n pulsed low during WAIT_DONE of a c1 read -> all outputs 0 within the reset; no c1_done; after release, first contended grant goes to client 0.

Source files
------------

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: single-command port between the arbiter and
// the 8-bit PSRAM controller.
interface psram_arbiter_if;
    logic        stb;
    logic        we;
    logic [23:0] addr;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;

    modport master (
        output stb, we, addr, din,
        input  busy, done, dout
    );

    modport slave (
        input  stb, we, addr, din,
        output busy, done, dout
    );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-client round-robin front end for the PSRAM
// controller command port, with an accept/complete watchdog.
module psram_arbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic           arst_n,
    input  logic           i_clk,
    input  logic           c0_req,
    input  logic           c0_we,
    input  logic [23:0]    c0_addr,
    input  logic [15:0]    c0_din,
    output logic           c0_ack,
    output logic           c0_done,
    output logic           c0_err,
    output logic [15:0]    c0_dout,
    input  logic           c1_req,
    input  logic           c1_we,
    input  logic [23:0]    c1_addr,
    input  logic [15:0]    c1_din,
    output logic           c1_ack,
    output logic           c1_done,
    output logic           c1_err,
    output logic [15:0]    c1_dout,
    psram_arbiter_if.master m
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_ACC  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state;
    logic             last_grant;
    logic             gnt;
    logic             stb_q;
    logic             we_q;
    logic [23:0]      addr_q;
    logic [15:0]      din_q;
    logic [CNT_W-1:0] wd;

    logic m_ready;
    logic can_grant;
    logic win1;
    logic accepted;
    logic wd_hit;
    logic fin_ok;
    logic fin_err;
    logic fin;

    assign m_ready  = m.done & ~m.busy;
    assign accepted = m.busy | ~m.done;
    assign wd_hit   = (wd == WD_LAST);

    // The cycle carrying a done pulse is kept free of acks, which
    // guarantees one idle cycle before the next grant.
    assign can_grant = (state == IDLE) & m_ready
                     & ~(c0_done | c1_done)
                     & (c0_req | c1_req);

    always_comb begin
        win1 = 1'b0;
        unique case (1'b1)
            c0_req & c1_req:  win1 = ~last_grant;
            c1_req & ~c0_req: win1 = 1'b1;
            default:          win1 = 1'b0;
        endcase
    end

    assign c0_ack = can_grant & ~win1;
    assign c1_ack = can_grant & win1;

    assign fin_ok  = (state == WAIT_DONE) & m_ready;
    assign fin_err = wd_hit
                   & (((state == WAIT_ACC) & ~accepted)
                   | ((state == WAIT_DONE) & ~m_ready));
    assign fin     = fin_ok | fin_err;

    assign m.stb  = stb_q;
    assign m.we   = we_q;
    assign m.addr = addr_q;
    assign m.din  = din_q;

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            wd         <= '0;
            c0_done    <= 1'b0;
            c0_err     <= 1'b0;
            c0_dout    <= '0;
            c1_done    <= 1'b0;
            c1_err     <= 1'b0;
            c1_dout    <= '0;
        end else begin
            stb_q   <= 1'b0;
            c0_done <= fin & ~gnt;
            c1_done <= fin & gnt;
            c0_err  <= fin_err & ~gnt;
            c1_err  <= fin_err & gnt;
            if (fin_ok & ~we_q & ~gnt) begin
                c0_dout <= m.dout;
            end
            if (fin_ok & ~we_q & gnt) begin
                c1_dout <= m.dout;
            end
            if (fin) begin
                last_grant <= gnt;
            end
            unique case (state)
                IDLE: begin
                    if (can_grant) begin
                        gnt    <= win1;
                        we_q   <= win1 ? c1_we : c0_we;
                        addr_q <= win1 ? c1_addr : c0_addr;
                        din_q  <= win1 ? c1_din : c0_din;
                        stb_q  <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT_ACC;
                end
                WAIT_ACC: begin
                    if (accepted) begin
                        wd    <= '0;
                        state <= WAIT_DONE;
                    end else if (fin) begin
                        state <= IDLE;
                    end else begin
                        wd <= wd + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (fin) begin
                        state <= IDLE;
                    end else begin
                        wd <= wd + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed vectors plus multi-cycle sequences
// against a small behavioural PSRAM controller model.
module tb_psram_arbiter;

    typedef struct {
        int          cl;
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
        logic [15:0] rdata;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
    } vec_t;

    logic        i_clk  = 1'b0;
    logic        arst_n = 1'b0;
    logic        c0_req = 1'b0, c0_we = 1'b0;
    logic [23:0] c0_addr = '0;
    logic [15:0] c0_din = '0;
    logic        c0_ack, c0_done, c0_err;
    logic [15:0] c0_dout;
    logic        c1_req = 1'b0, c1_we = 1'b0;
    logic [23:0] c1_addr = '0;
    logic [15:0] c1_din = '0;
    logic        c1_ack, c1_done, c1_err;
    logic [15:0] c1_dout;

    psram_arbiter_if mif();

    psram_arbiter #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
        .arst_n (arst_n),
        .i_clk  (i_clk),
        .c0_req (c0_req),
        .c0_we  (c0_we),
        .c0_addr(c0_addr),
        .c0_din (c0_din),
        .c0_ack (c0_ack),
        .c0_done(c0_done),
        .c0_err (c0_err),
        .c0_dout(c0_dout),
        .c1_req (c1_req),
        .c1_we  (c1_we),
        .c1_addr(c1_addr),
        .c1_din (c1_din),
        .c1_ack (c1_ack),
        .c1_done(c1_done),
        .c1_err (c1_err),
        .c1_dout(c1_dout),
        .m      (mif)
    );

    always #5 i_clk = ~i_clk;

    int          n_run = 0;
    int          n_fail = 0;
    int          busy_left = 0;
    int          init_hold = 100;
    int          mode = 0;
    logic [15:0] rdata = '0;
    int          gq[$];
    int          ovl = 0;
    logic        outst = 1'b0;

    // Controller model: mode 0 completes after 3 busy cycles,
    // mode 1 ignores strobes, mode 2 accepts and never finishes.
    always @(posedge i_clk) begin
        logic st;
        st = mif.stb;
        #1;
        if (!arst_n) begin
            busy_left = init_hold;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (st) begin
            if (mode == 0) begin
                busy_left = 3;
                mif.dout  = rdata;
            end else if (mode == 2) begin
                busy_left = 1000000;
            end
        end
        mif.busy = (busy_left > 0);
        mif.done = !(busy_left > 0);
    end

    always @(posedge i_clk) begin
        if (!arst_n) begin
            outst = 1'b0;
        end else begin
            if (c0_ack) gq.push_back(0);
            if (c1_ack) gq.push_back(1);
            if (mif.stb) begin
                if (outst) ovl++;
                outst = 1'b1;
            end
            if (c0_done | c1_done) outst = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{c0_ack, c0_done, c0_err, c0_dout,
                 c1_ack, c1_done, c1_err, c1_dout,
                 mif.stb, mif.we, mif.addr, mif.din};
    endfunction

    task automatic get_ack(input int cl, input logic we,
                           input logic [23:0] a, input logic [15:0] d,
                           input int budget, output int waited,
                           output logic early);
        logic hit;
        hit    = 1'b0;
        waited = 0;
        early  = 1'b0;
        if (cl == 0) begin
            c0_we = we; c0_addr = a; c0_din = d; c0_req = 1'b1;
        end else begin
            c1_we = we; c1_addr = a; c1_din = d; c1_req = 1'b1;
        end
        while (!hit && waited < budget) begin
            #1;
            hit = (cl == 0) ? c0_ack : c1_ack;
            if (mif.stb) early = 1'b1;
            if (!hit) begin
                @(negedge i_clk);
                waited++;
            end
        end
        check($sformatf("c%0d_ack_seen", cl), hit, 1);
        @(negedge i_clk);
        if (cl == 0) c0_req = 1'b0;
        else c1_req = 1'b0;
    endtask

    task automatic wait_done(input int cl, input int budget,
                             output int n, output logic seen,
                             output logic err, output logic other);
        n = 0; seen = 1'b0; err = 1'b0; other = 1'b0;
        while (!seen && n < budget) begin
            @(negedge i_clk);
            n++;
            if ((cl == 0) ? c1_done : c0_done) other = 1'b1;
            if ((cl == 0) ? c0_done : c1_done) begin
                seen = 1'b1;
                err  = (cl == 0) ? c0_err : c1_err;
            end
        end
    endtask

    task automatic do_access(input vec_t v, input int budget,
                             output int waited);
        logic early, seen, err, other;
        int   n;
        rdata = v.rdata;
        get_ack(v.cl, v.we, v.addr, v.din, budget, waited, early);
        check("no_stb_before_ack", early, 0);
        check("stb_on", mif.stb, 1);
        check("stb_we", mif.we, v.we);
        check("stb_addr", mif.addr, v.addr);
        check("stb_din", mif.din, v.din);
        @(negedge i_clk);
        check("stb_single", mif.stb, 0);
        wait_done(v.cl, 50, n, seen, err, other);
        check("done_seen", seen, 1);
        check("done_err", err, 0);
        check("other_quiet", other, 0);
        check("c0_dout", c0_dout, v.exp_d0);
        check("c1_dout", c1_dout, v.exp_d1);
    endtask

    initial begin
        vec_t tbl[4];
        vec_t v;
        int   w, n, dn, start;
        logic early, seen, err, other, bad;

        tbl[0] = '{1, 1'b0, 24'h000010, 16'h0000, 16'hA5C3,
                   16'h0000, 16'hA5C3};
        tbl[1] = '{0, 1'b0, 24'h00ABCD, 16'h0000, 16'h1234,
                   16'h1234, 16'hA5C3};
        tbl[2] = '{0, 1'b1, 24'h000000, 16'hFFFF, 16'h5555,
                   16'h1234, 16'hA5C3};
        tbl[3] = '{1, 1'b1, 24'hFFFFFF, 16'h0F0F, 16'hDEAD,
                   16'h1234, 16'hA5C3};

        // Power-up: controller busy for 100 cycles, c0 waiting.
        c0_we = 1'b1; c0_addr = 24'h123456; c0_din = 16'hBEEF;
        c0_req = 1'b1;
        repeat (3) @(negedge i_clk);
        check("reset_outputs_zero", any_out(), 0);
        arst_n = 1'b1;
        v = '{0, 1'b1, 24'h123456, 16'hBEEF, 16'h0000,
              16'h0000, 16'h0000};
        do_access(v, 300, w);
        check("init_hold_cycles", (w >= 99 && w <= 101), 1);

        for (int i = 0; i < 4; i++) begin
            do_access(tbl[i], 50, w);
        end

        // Both clients contend for six accesses.
        c0_we = 1'b1; c0_addr = 24'h000020; c0_din = 16'h1111;
        c1_we = 1'b1; c1_addr = 24'h000030; c1_din = 16'h2222;
        start = gq.size();
        c0_req = 1'b1; c1_req = 1'b1;
        dn = 0; n = 0;
        while (dn < 6 && n < 400) begin
            @(negedge i_clk);
            n++;
            if (c0_done) dn++;
            if (c1_done) dn++;
        end
        c0_req = 1'b0; c1_req = 1'b0;
        repeat (3) @(negedge i_clk);
        check("alt_done_count", dn, 6);
        check("alt_ack_count", gq.size() - start, 6);
        for (int i = 0; i < 6; i++) begin
            if (start + i < gq.size())
                check($sformatf("alt_grant_%0d", i), gq[start + i], i % 2);
        end
        check("no_overlap", ovl, 0);

        // Controller never accepts: watchdog abort.
        mode = 1;
        get_ack(0, 1'b0, 24'h000100, 16'h0000, 50, w, early);
        check("to_stb_on", mif.stb, 1);
        wait_done(0, 100, n, seen, err, other);
        check("to_done_seen", seen, 1);
        check("to_err", err, 1);
        check("to_cycles", n, 65);
        check("to_other_quiet", other, 0);
        check("to_c0_dout_held", c0_dout, 16'h1234);
        check("to_c1_dout_held", c1_dout, 16'hA5C3);

        mode = 0;
        v = '{1, 1'b0, 24'h000200, 16'h0000, 16'h7E57,
              16'h1234, 16'h7E57};
        do_access(v, 50, w);

        // Reset while a c1 read sits in WAIT_DONE.
        mode = 2;
        get_ack(1, 1'b0, 24'h000300, 16'h0000, 50, w, early);
        repeat (4) @(negedge i_clk);
        init_hold = 5;
        arst_n = 1'b0;
        #1;
        check("rst_outputs_zero", any_out(), 0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (c1_done | any_out()) bad = 1'b1;
        end
        check("rst_quiet", bad, 0);
        mode = 0;
        arst_n = 1'b1;
        c0_we = 1'b0; c0_addr = 24'h000400;
        c1_we = 1'b0; c1_addr = 24'h000500;
        c0_req = 1'b1; c1_req = 1'b1;
        bad = 1'b0; n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            #1;
            if (c1_done) bad = 1'b1;
            seen = c0_ack | c1_ack;
            if (!seen) begin
                @(negedge i_clk);
                n++;
            end
        end
        check("rst_no_c1_done", bad, 0);
        check("rst_first_grant", {c0_ack, c1_ack}, 2'b10);
        @(negedge i_clk);
        c0_req = 1'b0; c1_req = 1'b0;
        wait_done(0, 50, n, seen, err, other);
        check("rst_c0_done", seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
